// File: rtl/alu_cmd_driver.sv
// Command-side sequencer for the 3-bit ALU: register operands, wait settle time, queue tagged results.
// Optional result self-check enabled by defining ALU_CMD_DRIVER_CHECK_EN.
//   state   | meaning
//   IDLE    | no command in flight; accepts when the response FIFO has room
//   WAIT    | operands driven to the ALU, settle counter running down to sample
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 1,
  parameter int RSP_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [4:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic       rsp_mismatch
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    a_q, a_d, b_q, b_d, op_q, op_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    data_mem_q [RSP_DEPTH];
  logic [4:0]    data_mem_d [RSP_DEPTH];
  logic [2:0]    op_mem_q   [RSP_DEPTH];
  logic [2:0]    op_mem_d   [RSP_DEPTH];
  logic          err_mem_q  [RSP_DEPTH];
  logic          err_mem_d  [RSP_DEPTH];

  logic accept, push, pop, div_zero;

  assign cmd_ready = (state_q == ST_IDLE) && (count_q < CW'(RSP_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign div_zero  = ((op_q == 3'b011) || (op_q == 3'b100)) && (b_q == 3'd0);

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_data = data_mem_q[rd_ptr_q];
  assign rsp_op   = op_mem_q[rd_ptr_q];
  assign rsp_err  = err_mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_mem_d = data_mem_q;
    op_mem_d   = op_mem_q;
    err_mem_d  = err_mem_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = div_zero ? 5'd0 : alu_out;
      op_mem_d[wr_ptr_q]   = op_q;
      err_mem_d[wr_ptr_q]  = div_zero;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        op_mem_q[i]   <= '0;
        err_mem_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_mem_q <= data_mem_d;
      op_mem_q   <= op_mem_d;
      err_mem_q  <= err_mem_d;
    end
  end

`ifdef ALU_CMD_DRIVER_CHECK_EN
  // Reference model uses zero-extended 5-bit operands so wrap matches the ALU.
  logic [4:0] exp_res, ea, eb;
  logic       mm_mem_q [RSP_DEPTH];
  logic       mm_mem_d [RSP_DEPTH];

  always_comb begin
    ea = {2'b00, a_q};
    eb = {2'b00, b_q};
    exp_res = 5'd0;
    case (op_q)
      3'b000: exp_res = ea + eb;
      3'b001: exp_res = ea - eb;
      3'b010: exp_res = ea * eb;
      3'b011: exp_res = (eb != 5'd0) ? ea / eb : 5'd0;
      3'b100: exp_res = (eb != 5'd0) ? ea % eb : 5'd0;
      3'b101: exp_res = ea & eb;
      3'b110: exp_res = ea | eb;
      3'b111: exp_res = ea ^ eb;
      default: exp_res = 5'd0;
    endcase
  end

  always_comb begin
    mm_mem_d = mm_mem_q;
    if (push) mm_mem_d[wr_ptr_q] = !div_zero && (alu_out != exp_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) mm_mem_q[i] <= 1'b0;
    end else begin
      mm_mem_q <= mm_mem_d;
    end
  end

  assign rsp_mismatch = mm_mem_q[rd_ptr_q];
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with an ALU stub and a response scoreboard.
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
  logic [2:0] alu_a, alu_b, alu_op;
  logic [4:0] alu_out;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [4:0] rsp_data;
  logic [2:0] rsp_op;
  logic       rsp_err, rsp_mismatch;

  logic       cmd_valid3 = 1'b0, cmd_ready3;
  logic [2:0] cmd_a3 = '0, cmd_b3 = '0, cmd_op3 = '0;
  logic [2:0] alu_a3, alu_b3, alu_op3;
  logic [4:0] alu_out3 = '0;
  logic       rsp_valid3, rsp_ready3 = 1'b1;
  logic [4:0] rsp_data3;
  logic [2:0] rsp_op3;
  logic       rsp_err3, rsp_mismatch3;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0] data;
    logic [2:0] op;
    logic       err;
    logic       mm;
  } exp_t;
  exp_t sb[$];

  logic       force_en = 1'b0;
  logic [4:0] force_val = '0;

  // ALU stub; divide/modulus by zero returns all ones so the driver's forcing to 0 is visible.
  function automatic logic [4:0] alu_ref(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    logic [4:0] x, y;
    x = {2'b00, a};
    y = {2'b00, b};
    case (op)
      3'b000: return x + y;
      3'b001: return x - y;
      3'b010: return x * y;
      3'b011: return (y != 0) ? x / y : 5'h1f;
      3'b100: return (y != 0) ? x % y : 5'h1f;
      3'b101: return x & y;
      3'b110: return x | y;
      default: return x ^ y;
    endcase
  endfunction

  assign alu_out = force_en ? force_val : alu_ref(alu_a, alu_b, alu_op);

  alu_cmd_driver #(.SETTLE_CYCLES(1), .RSP_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch)
  );

  alu_cmd_driver #(.SETTLE_CYCLES(3), .RSP_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_out(alu_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_op(rsp_op3), .rsp_err(rsp_err3), .rsp_mismatch(rsp_mismatch3)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one command (called at posedge+1); returns at posedge+1 after the accept edge.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    exp_t e;
    logic [4:0] raw;
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    assert (cmd_ready === 1'b1) else begin
      failures++;
      $error("FAIL send_timeout observed cmd_ready=%0b expected=1", cmd_ready);
    end
    if (cmd_ready) begin
      raw   = force_en ? force_val : alu_ref(a, b, op);
      e.err = ((op == 3'b011) || (op == 3'b100)) && (b == 3'd0);
      e.data = e.err ? 5'd0 : raw;
      e.op  = op;
      e.mm  = 1'b0;
`ifdef ALU_CMD_DRIVER_CHECK_EN
      e.mm  = !e.err && (raw != alu_ref(a, b, op));
`endif
      sb.push_back(e);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_rsp observed data=%0d queued=%0d expected queued>0", rsp_data, sb.size());
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_op", {2'b00, rsp_op}, {2'b00, e.op});
        chk("rsp_err", {4'b0, rsp_err}, {4'b0, e.err});
        chk("rsp_mismatch", {4'b0, rsp_mismatch}, {4'b0, e.mm});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(3);
    chk("rst_rsp_valid", {4'b0, rsp_valid}, 5'd0);
    chk("rst_alu_a", {2'b0, alu_a}, 5'd0);
    chk("rst_rsp_data", rsp_data, 5'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", {4'b0, cmd_ready}, 5'd1);
    chk("idle_rsp_err", {4'b0, rsp_err}, 5'd0);
    chk("idle_rsp_mm", {4'b0, rsp_mismatch}, 5'd0);

    // add with latency check
    send(3'd5, 3'd3, 3'b000);
    chk("acc_alu_a", {2'b0, alu_a}, 5'd5);
    chk("acc_alu_b", {2'b0, alu_b}, 5'd3);
    chk("acc_alu_op", {2'b0, alu_op}, 5'd0);
    chk("acc_cmd_ready", {4'b0, cmd_ready}, 5'd0);
    chk("acc_rsp_valid", {4'b0, rsp_valid}, 5'd0);
    tick();
    chk("lat_rsp_valid", {4'b0, rsp_valid}, 5'd1);
    chk("lat_cmd_ready", {4'b0, cmd_ready}, 5'd1);
    chk("add_data", rsp_data, 5'd8);

    send(3'd2, 3'd5, 3'b001); tick(); chk("sub_data", rsp_data, 5'b11101);
    send(3'd7, 3'd7, 3'b010); tick(); chk("mul_data", rsp_data, 5'd17);
    send(3'd6, 3'd0, 3'b011); tick(); chk("div0_err", {4'b0, rsp_err}, 5'd1); chk("div0_data", rsp_data, 5'd0);
    send(3'd6, 3'd0, 3'b100); tick(); chk("mod0_err", {4'b0, rsp_err}, 5'd1);
    send(3'd6, 3'd4, 3'b100); tick(); chk("mod_data", rsp_data, 5'd2); chk("mod_err", {4'b0, rsp_err}, 5'd0);
    for (int op = 5; op < 8; op++) begin
      send(3'd5, 3'd3, 3'(op));
      tick();
    end
    tick(2);

    // backpressure: fill the FIFO, hold a fifth command off
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'(i + 1), 3'd2, 3'b000);
    tick();
    chk("full_cmd_ready", {4'b0, cmd_ready}, 5'd0);
    chk("full_rsp_valid", {4'b0, rsp_valid}, 5'd1);
    cmd_a = 3'd7; cmd_b = 3'd1; cmd_op = 3'b001; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_cmd_ready", {4'b0, cmd_ready}, 5'd0);
      chk("stall_head_data", rsp_data, 5'd3);
    end
    rsp_ready = 1'b1;
    send(3'd7, 3'd1, 3'b001);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick(2);
    chk("drain_sb_empty", 5'(sb.size()), 5'd0);
    chk("drain_rsp_valid", {4'b0, rsp_valid}, 5'd0);

`ifdef ALU_CMD_DRIVER_CHECK_EN
    force_en = 1'b1; force_val = 5'd30;
    send(3'd1, 3'd1, 3'b000);
    tick();
    chk("mm_flag", {4'b0, rsp_mismatch}, 5'd1);
    force_en = 1'b0;
    tick(2);
`endif

    // SETTLE_CYCLES=3: only the value present on the third edge is captured
    alu_out3 = 5'd7;
    cmd_a3 = 3'd1; cmd_b3 = 3'd1; cmd_op3 = 3'b000;
    chk("s3_cmd_ready", {4'b0, cmd_ready3}, 5'd1);
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    alu_out3 = 5'd9;
    chk("s3_n0_valid", {4'b0, rsp_valid3}, 5'd0);
    tick();
    alu_out3 = 5'd10;
    chk("s3_n1_valid", {4'b0, rsp_valid3}, 5'd0);
    tick();
    alu_out3 = 5'd21;
    chk("s3_n2_valid", {4'b0, rsp_valid3}, 5'd0);
    chk("s3_n2_ready", {4'b0, cmd_ready3}, 5'd0);
    tick();
    chk("s3_n3_valid", {4'b0, rsp_valid3}, 5'd1);
    chk("s3_n3_data", rsp_data3, 5'd21);
    chk("s3_n3_ready", {4'b0, cmd_ready3}, 5'd1);
    tick(2);

    // reset during WAIT with two entries queued
    rsp_ready = 1'b0;
    send(3'd1, 3'd1, 3'b000); tick();
    send(3'd2, 3'd2, 3'b000); tick();
    send(3'd3, 3'd3, 3'b000);
    rst_n = 1'b0;
    #2;
    sb.delete();
    chk("mid_rst_rsp_valid", {4'b0, rsp_valid}, 5'd0);
    chk("mid_rst_alu_a", {2'b0, alu_a}, 5'd0);
    chk("mid_rst_rsp_data", rsp_data, 5'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rsp_valid", {4'b0, rsp_valid}, 5'd0);
    chk("post_rst_cmd_ready", {4'b0, cmd_ready}, 5'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_stale", {4'b0, rsp_valid}, 5'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Command-side initiator for the 3-bit combinational ALU.
- Accepts operation commands over a valid/ready interface and drives the ALU's A, B and OP inputs from registers.
- Waits a configurable settle time, samples the ALU's 5-bit result, flags divide/modulus-by-zero, and queues tagged results in a response FIFO.
- Sits between the command source and the ALU instance; owns all sequencing around the ALU.

Parameters:
- SETTLE_CYCLES, 1, clock edges from command accept to sampling alu_out (legal range 1..15).
- RSP_DEPTH, 4, response FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept a command
- cmd_a  input  3  operand A
- cmd_b  input  3  operand B
- cmd_op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor
- alu_a  output  3  registered operand A to the ALU
- alu_b  output  3  registered operand B to the ALU
- alu_op  output  3  registered opcode to the ALU
- alu_out  input  5  ALU result
- rsp_valid  output  1  FIFO head valid
- rsp_ready  input  1  consumer takes head
- rsp_data  output  5  result at head
- rsp_op  output  3  opcode of head
- rsp_err  output  1  head was div/mod with B=0
- rsp_mismatch  output  1  see Optional Feature

Behaviour:
- Reset: clk with rst_n asynchronous, active low.
  - State goes to IDLE; settle counter to 0; FIFO emptied.
  - alu_a, alu_b, alu_op go to 0.
  - rsp_valid, rsp_data, rsp_op, rsp_err, rsp_mismatch go to 0.
  - No command is accepted while rst_n=0.
- FSM states: IDLE, WAIT.
- cmd_ready = (state==IDLE) && (FIFO count < RSP_DEPTH). It is combinational from state and count, never from cmd_valid.
- Accept:
  - A command is accepted on a rising edge with cmd_valid && cmd_ready.
  - On that edge: alu_a/b/op load cmd_a/b/op, the counter loads SETTLE_CYCLES-1, and the state goes to WAIT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==0 (the SETTLE_CYCLES-th edge after accept), alu_out is sampled and pushed to the FIFO, and the state returns to IDLE.
- Hold and throughput:
  - alu_a/b/op hold their values until the next accept.
  - One command is in flight at most; throughput is one command per SETTLE_CYCLES+1 cycles.
- Error:
  - Set when alu_op is 011 or 100 and alu_b==0. rsp_err=1 and the stored rsp_data is forced to 5'd0.
  - Otherwise rsp_data = alu_out unchanged. Wrap/truncation is the ALU's; the driver does no arithmetic.
- FIFO:
  - Pop on the rising edge with rsp_valid && rsp_ready.
  - Push and pop on the same edge are both honoured and the count is unchanged.
  - rsp_* reflect the head combinationally from FIFO storage; rsp_valid = count!=0.
  - Head fields hold stable while rsp_valid && !rsp_ready.
- Full: with count==RSP_DEPTH, cmd_ready=0. A push can never overflow, since accept requires free space and there is only one in flight.
- Latency: with SETTLE_CYCLES=1 and an empty FIFO, accept at edge N gives rsp_valid=1 after edge N+1, and cmd_ready is high again after edge N+1.
- Reset mid-operation: the in-flight command is dropped with no response; queued responses are discarded.

Optional Feature:
- Macro: ALU_CMD_DRIVER_CHECK_EN.
- Defined:
  - An internal model computes the expected 5-bit result from alu_a/b/op, using the same 5-bit-wide semantics as the ALU.
  - Divide/modulus by zero is excluded from checking.
  - A mismatch at the sample edge is stored with the entry and presented on rsp_mismatch.
- Undefined: rsp_mismatch is tied to 0 and no model logic is built.

Test Plan:
- Reset, then cmd {a=5, b=3, op=000}, rsp_ready=1 -> alu_a=5, alu_b=3, alu_op=000 after accept. rsp_valid one edge later with rsp_data=8, rsp_op=000, rsp_err=0.
- Sub and mul: {2,5,001} -> rsp_data=5'b11101. {7,7,010} -> rsp_data=17 (49 truncated to 5 bits).
- Divide by zero: {6,0,011} -> rsp_err=1, rsp_data=0. {6,0,100} -> rsp_err=1. {6,4,100} -> rsp_data=2, rsp_err=0.
- Backpressure: rsp_ready=0, issue 5 commands with RSP_DEPTH=4 -> cmd_ready low after the 4th push. Release rsp_ready -> 4 responses pop in order, then the 5th is accepted.
- SETTLE_CYCLES=3: accept at edge N -> sample at edge N+3. Change alu_out at N+1/N+2 -> only the value present at N+3 is captured.
- Reset asserted during WAIT with 2 entries queued -> rsp_valid=0 and cmd_ready=1 after release; no stale response appears. With CHECK_EN and a faulty ALU stub -> rsp_mismatch=1.
